dmem_arbiter: RTL and testbench

Arbitrates between two requesters (port 0: pipeline MEM stage; port 1: debug/DMA loader) for the single-port, word-addressed data memory. Grants at most one access per cycle, with round-robin fairness and bounded bursts. Drives the memory's write-enable, address and write-data inputs. Returns read data to the granted requester one cycle after the grant, as a registered value with a valid strobe.

---
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory, with bounded bursts
// and a registered read-return path (rvalid/rdata one cycle after a read grant).
module dmem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [1:0]       dbg_owner,
  output logic [CNT_W-1:0] dbg_cnt
);

  // Handshake: a requester holds req/we/addr/wdata stable until gnt is seen high in
  // the same cycle; gnt means the access is performed at the next rising edge.
  // Dropping req before gnt withdraws the request with no side effect.

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  owner_t           owner_q, owner_d;
  logic             last_q, last_d;   // 0: port 0 granted last, 1: port 1
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0, gnt1;
  logic             burst_open;

  assign burst_open = (cnt_q < BURST_MAX);

  // Grant decision; reset masks every grant so nothing reaches memory during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req && !m1_req) begin
        gnt0 = 1'b1;
      end else if (m1_req && !m0_req) begin
        gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        if (owner_q == OWN_P0 && burst_open) begin
          gnt0 = 1'b1;
        end else if (owner_q == OWN_P1 && burst_open) begin
          gnt1 = 1'b1;
        end else if (last_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    cnt_d   = '0;
    last_d  = last_q;
    if (gnt0) begin
      owner_d = OWN_P0;
      last_d  = 1'b0;
      if (owner_q == OWN_P0) begin
        cnt_d = (cnt_q == BURST_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
        cnt_d = CNT_ONE;
      end
    end else if (gnt1) begin
      owner_d = OWN_P1;
      last_d  = 1'b1;
      if (owner_q == OWN_P1) begin
        cnt_d = (cnt_q == BURST_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
        cnt_d = CNT_ONE;
      end
    end
  end

  always_comb begin
    mem_we    = (gnt0 & m0_we) | (gnt1 & m1_we);
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // Reset leaves last = port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt0 & ~m0_we;
      m1_rvalid <= gnt1 & ~m1_we;
      if (gnt0 && !m0_we) m0_rdata <= mem_rdata;
      if (gnt1 && !m1_we) m1_rdata <= mem_rdata;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign dbg_owner = owner_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural word memory, expected-read-data
// queues per port, grant expectations written out per cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_owner;
  logic [2:0]  dbg_cnt;

  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic        pend0, pend1;
  int          tests, fails;
  logic [31:0] d0, d1;

  dmem_arbiter #(.BURST_LEN(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_owner(dbg_owner), .dbg_cnt(dbg_cnt)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One cycle with the inputs already driven: check at the falling edge, then
  // record the read returns expected one cycle later.
  task automatic tick(input logic e_g0, input logic e_g1,
                      input logic [31:0] e_d0, input logic [31:0] e_d1);
    @(negedge clk);
    chk("m0_gnt", m0_gnt, e_g0);
    chk("m1_gnt", m1_gnt, e_g1);
    chk("mem_we", mem_we, (e_g0 & m0_we) | (e_g1 & m1_we));
    if (e_g1) begin
      chk("mem_addr_p1", mem_addr, m1_addr);
      chk("mem_wdata_p1", mem_wdata, m1_wdata);
    end else if (e_g0) begin
      chk("mem_addr_p0", mem_addr, m0_addr);
    end
    chk("m0_rvalid", m0_rvalid, pend0);
    chk("m1_rvalid", m1_rvalid, pend1);
    if (m0_rvalid && exp_q0.size() > 0) chk("m0_rdata", m0_rdata, exp_q0.pop_front());
    if (m1_rvalid && exp_q1.size() > 0) chk("m1_rdata", m1_rdata, exp_q1.pop_front());
    pend0 = e_g0 & ~m0_we;
    pend1 = e_g1 & ~m1_we;
    if (pend0) exp_q0.push_back(e_d0);
    if (pend1) exp_q1.push_back(e_d1);
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0; fails = 0; pend0 = 1'b0; pend1 = 1'b0;
    rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    d0 = $urandom_range(32'h7fff_ffff, 1);
    d1 = $urandom_range(32'h7fff_ffff, 1) | 32'h8000_0000;

    // Memory preload while reset is held.
    preload(10'd5, 32'hDEADBEEF);
    preload(10'd64, d0);
    preload(10'd128, d1);
    preload(10'd32, 32'hCAFE0032);

    // Reset state, with a write request present that must be blocked.
    m0_req = 1; m0_we = 1; m0_addr = 32'h80; m0_wdata = 32'h1111_1111;
    @(negedge clk);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_owner", dbg_owner, 0);
    chk("rst_cnt", dbg_cnt, 0);
    @(posedge clk); #1;
    m0_req = 0; m0_we = 0;
    rst = 1'b0;

    // Single read on port 0.
    m0_req = 1; m0_we = 0; m0_addr = 32'h14;
    tick(1, 0, 32'hDEADBEEF, 0);
    m0_req = 0;
    tick(0, 0, 0, 0);

    // Write then read on port 1.
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h12345678;
    tick(0, 1, 0, 0);
    m1_we = 0; m1_wdata = 32'h0;
    tick(0, 1, 0, 32'h12345678);
    m1_req = 0;
    tick(0, 0, 0, 0);

    // Tie after reset: 4/4 alternation starting with port 0.
    rst = 1'b1; #2; rst = 1'b0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    for (int i = 0; i < 16; i++) begin
      tick(((i / 4) % 2) == 0, ((i / 4) % 2) == 1, d0, d1);
    end
    m0_req = 0; m1_req = 0;
    tick(0, 0, 0, 0);

    // Lone requester bursts past the limit; counter saturates.
    m0_req = 1; m0_addr = 32'h14;
    for (int i = 0; i < 10; i++) tick(1, 0, 32'hDEADBEEF, 0);
    chk("burst_cnt_sat", dbg_cnt, 4);
    chk("burst_owner_p0", dbg_owner, 1);
    m1_req = 1; m1_addr = 32'h200;
    tick(0, 1, 0, d1);
    m0_req = 0; m1_req = 0;
    tick(0, 0, 0, 0);

    // Reset during a port 1 read burst drops the pending rvalid.
    m1_req = 1; m1_addr = 32'h200;
    tick(0, 1, 0, d1);
    rst = 1'b1;
    #1;
    chk("midrst_m1_rvalid", m1_rvalid, 0);
    chk("midrst_m1_rdata", m1_rdata, 0);
    chk("midrst_m1_gnt", m1_gnt, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_cnt", dbg_cnt, 0);
    pend1 = 1'b0;
    exp_q1.delete();
    m0_req = 1; m0_addr = 32'h100;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1, 0, d0, 0);
    m0_req = 0; m1_req = 0;
    tick(0, 0, 0, 0);

    // Port 1 write request withdrawn while port 0 owns the burst.
    m0_req = 1; m0_addr = 32'h14;
    tick(1, 0, 32'hDEADBEEF, 0);
    m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'hBAD0_BAD0;
    tick(1, 0, 32'hDEADBEEF, 0);
    tick(1, 0, 32'hDEADBEEF, 0);
    m1_req = 0; m1_we = 0;
    tick(1, 0, 32'hDEADBEEF, 0);
    m0_req = 0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("cancel_no_write", mem[32], 32'hCAFE0032);
    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
